pio_cfg_seq: RTL
================

# pio_cfg_seq

Configuration sequencer for the `pio` block. On a start request it drives the `pio` action port through a fixed sequence:
- loads the program from a synchronous instruction memory;
- programs wrap, clock divider and pin groups for each selected state machine;
- enables those machines.

It sits between the SoC control logic and `pio`, and replaces hand-issued action writes.

## Interface
- `NUM_SM`, 4: number of state machines; `mindex` width is 2.
- `PROG_DEPTH`, 32: instruction memory depth; `index` and `prog_addr` width is 5.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `sm_mask`  in  4  machines to configure; captured at start
- `prog_len`  in  6  instructions to load; captured at start; values >32 clamp to 32
- `prog_addr`  out  5  instruction memory read address
- `prog_data`  in  16  instruction memory data; valid 1 cycle after `prog_addr`
- `cfg_sel`  out  2  machine whose config is requested
- `cfg_wrap`  in  5  wrap end for `cfg_sel`
- `cfg_div`  in  24  clock divider for `cfg_sel`
- `cfg_grps`  in  32  pin groups for `cfg_sel`
- `cfg_imm`  in  16  initial instruction for `cfg_sel`; only present with PIO_CFG_SEQ_IMM_EN
- `action`  out  4  to `pio.action`
- `index`  out  5  to `pio.index`
- `mindex`  out  2  to `pio.mindex`
- `din`  out  32  to `pio.din`
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle pulse at sequence end

## Operation
- States:
  - IDLE
  - FETCH: memory pipeline prime
  - LOAD
  - PEND
  - DIV
  - GRPS
  - IMM: macro only
  - ENABLE
  - FIN
- IDLE with `start`=1:
  - capture `sm_mask` and the clamped `prog_len`;
  - set `prog_addr` to 0 and `busy` to 1;
  - go to FETCH.
- FETCH advances `prog_addr` to 1 and goes to LOAD.
- LOAD:
  - each cycle emit `action`=INSTR(1), `index`=i, `din`={16'b0, prog_data}, for i = 0..len-1;
  - `prog_addr` runs one ahead and stops at len-1.
- Machine phase:
  - iterate over the set bits of `sm_mask` in ascending order;
  - per machine m, emit PEND(2) with `din`=cfg_wrap zero-extended;
  - then DIV(7) with `din`={8'b0, cfg_div};
  - then GRPS(5) with `din`=cfg_grps;
  - then IMM(9) with `din`={16'b0, cfg_imm} when the macro is compiled in;
  - `mindex`=m throughout.
- ENABLE: per set mask bit in ascending order, emit EN(6) with `din`=1 and `mindex`=m.
- FIN: `action`=NONE, `done`=1, `busy`=0, then IDLE.
- Empty phases are skipped with no idle cycles:
  - `prog_len`=0 skips LOAD;
  - `sm_mask`=0 skips the machine phase and ENABLE.
- Every action is held exactly one cycle. Actions are back-to-back with no gaps. `action`=NONE(0) in every cycle with no action.
- `start` while busy is ignored; no queuing.

## Timing
- All outputs are registered.
- Reset values: `action`=0, `index`=0, `mindex`=0, `din`=0, `prog_addr`=0, `cfg_sel`=0, `busy`=0, `done`=0; state is IDLE.
- Start latency: `start` sampled at edge E0; the first action is visible after edge E2.
- With total action count A = len + k·(3 or 4 with the macro) + k, where k = popcount(mask):
  - actions occupy cycles E2..E2+A-1;
  - `done` pulses in the cycle after E2+A-1;
  - with A=0, `done` pulses after E2.
- `cfg_sel` switches to machine m one cycle before m's PEND is emitted and holds through m's last config action.
- `cfg_*` are treated as combinational, zero-latency responses to `cfg_sel`.
- Reset asserted mid-sequence:
  - all outputs return to reset values immediately;
  - no further actions are emitted;
  - `pio` is left partially configured, and a new `start` is required.

## Configuration
- Macro: PIO_CFG_SEQ_IMM_EN.
- Defined:
  - the `cfg_imm` port exists;
  - the IMM state issues one immediate instruction per machine after GRPS and before ENABLE.
- Undefined:
  - the `cfg_imm` port and the IMM state are absent;
  - the per-machine phase is 3 actions.

## Structure
- Shared package `pio_pkg` holds:
  - the action code constants NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, IMM=9, SHIFT=10, IPINS=11, IDIRS=12;
  - the sequencer state enum typedef.
- One sub-module, `pio_sm_next`: combinational lowest-set-bit finder over the remaining mask (above the current machine). It returns the next machine index and a valid flag, and is used by both the machine phase and ENABLE.

## Test plan
- Basic load:
  - stimulus: `prog_len`=2, memory {E081, E001}, mask=0001, wrap=1, div=0x000280, grps=0x04000000;
  - response: INSTR(0,E081), INSTR(1,E001), PEND 1, DIV 0x280, GRPS 0x04000000, EN 1 on `mindex` 0;
  - `done` pulses 8 cycles after the start edge (macro off).
- Empty request: `prog_len`=0, mask=0 → no actions; `done` pulses after E2.
- Mask order: mask=1010, `prog_len`=1 → config for machine 1, then machine 3; EN for 1, then EN for 3; `cfg_sel` leads each PEND by one cycle.
- Clamp: `prog_len`=40 → exactly 32 INSTR actions with `index` 0..31; `prog_addr` never wraps.
- Busy/abort:
  - `start` pulsed during LOAD → ignored and the sequence is unchanged;
  - reset asserted during DIV → `action`=0 and `busy`=0 immediately;
  - next `start` replays the full sequence.
- Macro on: mask=0001, cfg_imm=0xE001 → IMM with `din`=0x0000E001 is emitted between GRPS and EN.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared pio definitions: action codes, sizing constants and the config sequencer state type.
// PIO_CFG_SEQ_IMM_EN adds the per-machine immediate-instruction state.
package pio_pkg;

    localparam int unsigned NUM_SM     = 4;
    localparam int unsigned SM_W       = 2;
    localparam int unsigned PROG_DEPTH = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned LEN_W      = 6;

    typedef logic [3:0] action_t;

    localparam action_t NONE  = 4'd0;
    localparam action_t INSTR = 4'd1;
    localparam action_t PEND  = 4'd2;
    localparam action_t PULL  = 4'd3;
    localparam action_t PUSH  = 4'd4;
    localparam action_t GRPS  = 4'd5;
    localparam action_t EN    = 4'd6;
    localparam action_t DIV   = 4'd7;
    localparam action_t SIDES = 4'd8;
    localparam action_t IMM   = 4'd9;
    localparam action_t SHIFT = 4'd10;
    localparam action_t IPINS = 4'd11;
    localparam action_t IDIRS = 4'd12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PEND,
        ST_DIV,
        ST_GRPS,
`ifdef PIO_CFG_SEQ_IMM_EN
        ST_IMM,
`endif
        ST_ENABLE,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/pio_cfg_seq_if.sv
// Signal bundle around the config sequencer: SoC request, instruction memory, config source, pio action port.
// PIO_CFG_SEQ_IMM_EN adds cfg_imm.
interface pio_cfg_seq_if;

    logic                         start;
    logic [pio_pkg::NUM_SM-1:0]   sm_mask;
    logic [pio_pkg::LEN_W-1:0]    prog_len;
    logic [pio_pkg::ADDR_W-1:0]   prog_addr;
    logic [15:0]                  prog_data;
    logic [pio_pkg::SM_W-1:0]     cfg_sel;
    logic [4:0]                   cfg_wrap;
    logic [23:0]                  cfg_div;
    logic [31:0]                  cfg_grps;
`ifdef PIO_CFG_SEQ_IMM_EN
    logic [15:0]                  cfg_imm;
`endif
    logic [3:0]                   action;
    logic [pio_pkg::ADDR_W-1:0]   index;
    logic [pio_pkg::SM_W-1:0]     mindex;
    logic [31:0]                  din;
    logic                         busy;
    logic                         done;

    modport master (
        output start, sm_mask, prog_len, prog_data, cfg_wrap, cfg_div, cfg_grps,
`ifdef PIO_CFG_SEQ_IMM_EN
        output cfg_imm,
`endif
        input  prog_addr, cfg_sel, action, index, mindex, din, busy, done
    );

    modport slave (
        input  start, sm_mask, prog_len, prog_data, cfg_wrap, cfg_div, cfg_grps,
`ifdef PIO_CFG_SEQ_IMM_EN
        input  cfg_imm,
`endif
        output prog_addr, cfg_sel, action, index, mindex, din, busy, done
    );

endinterface

// File: rtl/pio_sm_next.sv
// Lowest set bit of a machine mask at or above a starting position.
// `from` is one bit wider than the index so "past the last machine" is expressible.
module pio_sm_next
    import pio_pkg::*;
#(
    parameter int unsigned N = NUM_SM,
    parameter int unsigned W = SM_W
) (
    input  logic [N-1:0] mask,
    input  logic [W:0]   from,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (mask[i-1] && ((W+1)'(i-1) >= from)) begin
                idx   = W'(i-1);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_cfg_seq.sv
// Drives the pio action port through program load, per-machine config and enable on a start request.
// Build option PIO_CFG_SEQ_IMM_EN: issue one immediate instruction per machine after GRPS.
module pio_cfg_seq
    import pio_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    pio_cfg_seq_if.slave bus
);

    seq_state_e          state_q, state_d;
    logic [NUM_SM-1:0]   mask_q, mask_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
    logic [SM_W-1:0]     cur_q, cur_d;
    action_t             action_q, action_d;
    logic [ADDR_W-1:0]   index_q, index_d, prog_addr_q, prog_addr_d;
    logic [SM_W-1:0]     mindex_q, mindex_d, cfg_sel_q, cfg_sel_d;
    logic [31:0]         din_q, din_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic                enter_mach, next_mach;
    logic [SM_W:0]       nxt_from;
    logic [SM_W-1:0]     first_idx, nxt_idx;
    logic                first_vld, nxt_vld;

    assign nxt_from = {1'b0, cur_q} + 1'b1;

    pio_sm_next #(.N(NUM_SM), .W(SM_W)) u_first (
        .mask(mask_q), .from('0), .idx(first_idx), .valid(first_vld)
    );

    pio_sm_next #(.N(NUM_SM), .W(SM_W)) u_next (
        .mask(mask_q), .from(nxt_from), .idx(nxt_idx), .valid(nxt_vld)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        action_d    = NONE;
        index_d     = '0;
        mindex_d    = '0;
        din_d       = '0;
        prog_addr_d = prog_addr_q;
        cfg_sel_d   = cfg_sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        enter_mach  = 1'b0;
        next_mach   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d      = bus.sm_mask;
                    len_d       = (bus.prog_len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : bus.prog_len;
                    prog_addr_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                prog_addr_d = ADDR_W'(1);
                cnt_d       = '0;
                if (len_q != '0) state_d = ST_LOAD;
                else             enter_mach = 1'b1;
            end
            ST_LOAD: begin
                action_d = INSTR;
                index_d  = cnt_q[ADDR_W-1:0];
                din_d    = {16'h0, bus.prog_data};
                cnt_d    = cnt_q + 1'b1;
                // read address leads the emitted index by one and parks on the last word
                if (({1'b0, prog_addr_q} + 1'b1) < len_q) prog_addr_d = prog_addr_q + 1'b1;
                if ((cnt_q + 1'b1) == len_q) enter_mach = 1'b1;
            end
            ST_PEND: begin
                action_d = PEND;
                mindex_d = cur_q;
                din_d    = {27'h0, bus.cfg_wrap};
                state_d  = ST_DIV;
            end
            ST_DIV: begin
                action_d = DIV;
                mindex_d = cur_q;
                din_d    = {8'h0, bus.cfg_div};
                state_d  = ST_GRPS;
            end
            ST_GRPS: begin
                action_d = GRPS;
                mindex_d = cur_q;
                din_d    = bus.cfg_grps;
`ifdef PIO_CFG_SEQ_IMM_EN
                state_d  = ST_IMM;
`else
                next_mach = 1'b1;
`endif
            end
`ifdef PIO_CFG_SEQ_IMM_EN
            ST_IMM: begin
                action_d  = IMM;
                mindex_d  = cur_q;
                din_d     = {16'h0, bus.cfg_imm};
                next_mach = 1'b1;
            end
`endif
            ST_ENABLE: begin
                action_d = EN;
                mindex_d = cur_q;
                din_d    = 32'd1;
                if (nxt_vld) cur_d   = nxt_idx;
                else         state_d = ST_FIN;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // cfg_sel moves on the edge before PEND so cfg_* are settled when PEND samples them
        if (enter_mach) begin
            if (first_vld) begin
                state_d   = ST_PEND;
                cur_d     = first_idx;
                cfg_sel_d = first_idx;
            end else begin
                state_d   = ST_FIN;
            end
        end
        if (next_mach) begin
            if (nxt_vld) begin
                state_d   = ST_PEND;
                cur_d     = nxt_idx;
                cfg_sel_d = nxt_idx;
            end else begin
                state_d   = ST_ENABLE;
                cur_d     = first_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cur_q       <= '0;
            action_q    <= NONE;
            index_q     <= '0;
            mindex_q    <= '0;
            din_q       <= '0;
            prog_addr_q <= '0;
            cfg_sel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            action_q    <= action_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            din_q       <= din_d;
            prog_addr_q <= prog_addr_d;
            cfg_sel_q   <= cfg_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.action    = action_q;
    assign bus.index     = index_q;
    assign bus.mindex    = mindex_q;
    assign bus.din       = din_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.cfg_sel   = cfg_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
